// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: decodes M-extension instructions, steers each one to the mul or div unit
// and returns the registered result. Perf counters are built only with PCPI_DISPATCH_PERF_EN.
module pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int PERF_W         = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        pcpi_timeout,
    output logic        pcpi_mul_valid,
    input  logic        pcpi_mul_wr,
    input  logic [31:0] pcpi_mul_rd,
    input  logic        pcpi_mul_ready,
    output logic        pcpi_div_valid,
    input  logic        pcpi_div_wr,
    input  logic [31:0] pcpi_div_rd,
    input  logic        pcpi_div_ready
`ifdef PCPI_DISPATCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_mul_cnt,
    output logic [PERF_W-1:0] perf_div_cnt
`endif
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic             sel_div_r;
    logic [CNT_W-1:0] cnt_r;
    logic             wait_r;
    logic             ready_r;
    logic             timeout_r;
    logic             wr_r;
    logic [31:0]      rd_r;

    logic             match_s;
    logic             unit_ready_s;
    logic             unit_wr_s;
    logic [31:0]      unit_rd_s;
    logic             tmo_hit_s;
    logic             done_ok_s;

    // Instruction decode and selected-unit response mux; the other unit is never looked at.
    always_comb begin
        match_s = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
        if (sel_div_r) begin
            unit_ready_s = pcpi_div_ready;
            unit_wr_s    = pcpi_div_wr;
            unit_rd_s    = pcpi_div_rd;
        end else begin
            unit_ready_s = pcpi_mul_ready;
            unit_wr_s    = pcpi_mul_wr;
            unit_rd_s    = pcpi_mul_rd;
        end
        tmo_hit_s = (cnt_r == CNT_LAST);
        done_ok_s = (state_r == ST_BUSY) && pcpi_valid && unit_ready_s;
    end

    // Dispatch FSM; ready/wr/rd/timeout default low so they form single-cycle pulses in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            sel_div_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            wait_r    <= 1'b0;
            ready_r   <= 1'b0;
            timeout_r <= 1'b0;
            wr_r      <= 1'b0;
            rd_r      <= 32'd0;
        end else begin
            ready_r   <= 1'b0;
            timeout_r <= 1'b0;
            wr_r      <= 1'b0;
            rd_r      <= 32'd0;
            case (state_r)
                ST_IDLE: begin
                    if (pcpi_valid && match_s) begin
                        state_r   <= ST_BUSY;
                        sel_div_r <= pcpi_insn[14];
                        cnt_r     <= {CNT_W{1'b0}};
                        wait_r    <= 1'b1;
                    end else begin
                        wait_r    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // An abort beats a same-cycle unit response; a response beats the timeout.
                    if (!pcpi_valid) begin
                        state_r <= ST_IDLE;
                        wait_r  <= 1'b0;
                    end else if (unit_ready_s) begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b1;
                        wr_r    <= unit_wr_s;
                        rd_r    <= unit_rd_s;
                    end else if (tmo_hit_s) begin
                        state_r   <= ST_DONE;
                        ready_r   <= 1'b1;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    wait_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wait_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pcpi_wait      = wait_r;
    assign pcpi_ready     = ready_r;
    assign pcpi_timeout   = timeout_r;
    assign pcpi_wr        = wr_r;
    assign pcpi_rd        = rd_r;
    assign pcpi_mul_valid = (state_r == ST_BUSY) && !sel_div_r;
    assign pcpi_div_valid = (state_r == ST_BUSY) && sel_div_r;

    logic unused_insn_s;
    assign unused_insn_s = ^{pcpi_insn[24:15], pcpi_insn[13:7]};

`ifdef PCPI_DISPATCH_PERF_EN
    logic [PERF_W-1:0] perf_mul_r;
    logic [PERF_W-1:0] perf_div_r;

    // Completion counters; only ops finished by a real unit response are counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mul_r <= {PERF_W{1'b0}};
            perf_div_r <= {PERF_W{1'b0}};
        end else if (done_ok_s) begin
            if (sel_div_r) begin
                perf_div_r <= perf_div_r + {{(PERF_W-1){1'b0}}, 1'b1};
            end else begin
                perf_mul_r <= perf_mul_r + {{(PERF_W-1){1'b0}}, 1'b1};
            end
        end else begin
            perf_mul_r <= perf_mul_r;
            perf_div_r <= perf_div_r;
        end
    end

    assign perf_mul_cnt = perf_mul_r;
    assign perf_div_cnt = perf_div_r;
`else
    logic unused_perf_s;
    assign unused_perf_s = (PERF_W > 32'sd0) && done_ok_s;
`endif

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Randomized bench for pcpi_dispatch; expectations per transaction come from the decode rule,
// the unit response delay and the timeout limit using plain cycle arithmetic.
module tb_pcpi_dispatch;

    localparam int T = 8;

    logic        clk;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        pcpi_timeout;
    logic        pcpi_mul_valid;
    logic        pcpi_mul_wr;
    logic [31:0] pcpi_mul_rd;
    logic        pcpi_mul_ready;
    logic        pcpi_div_valid;
    logic        pcpi_div_wr;
    logic [31:0] pcpi_div_rd;
    logic        pcpi_div_ready;
`ifdef PCPI_DISPATCH_PERF_EN
    logic [31:0] perf_mul_cnt;
    logic [31:0] perf_div_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_mul = 0;
    int exp_div = 0;

    pcpi_dispatch #(.TIMEOUT_CYCLES(T), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
        .pcpi_ready(pcpi_ready), .pcpi_timeout(pcpi_timeout),
        .pcpi_mul_valid(pcpi_mul_valid), .pcpi_mul_wr(pcpi_mul_wr),
        .pcpi_mul_rd(pcpi_mul_rd), .pcpi_mul_ready(pcpi_mul_ready),
        .pcpi_div_valid(pcpi_div_valid), .pcpi_div_wr(pcpi_div_wr),
        .pcpi_div_rd(pcpi_div_rd), .pcpi_div_ready(pcpi_div_ready)
`ifdef PCPI_DISPATCH_PERF_EN
        , .perf_mul_cnt(perf_mul_cnt), .perf_div_cnt(perf_div_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_m(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001);
    endfunction

    // Selected unit gets the given response; the other unit gets random noise.
    task automatic drive_units(input logic dsel, input logic rdy, input logic wr, input logic [31:0] rd);
        logic [31:0] r;
        r = $urandom;
        if (dsel) begin
            pcpi_div_ready = rdy; pcpi_div_wr = wr; pcpi_div_rd = rd;
            pcpi_mul_ready = r[0]; pcpi_mul_wr = r[1]; pcpi_mul_rd = $urandom;
        end else begin
            pcpi_mul_ready = rdy; pcpi_mul_wr = wr; pcpi_mul_rd = rd;
            pcpi_div_ready = r[0]; pcpi_div_wr = r[1]; pcpi_div_rd = $urandom;
        end
    endtask

    task automatic drive_noise();
        logic [31:0] r;
        r = $urandom;
        drive_units(r[0], r[1], r[2], $urandom);
    endtask

    task automatic expect_cycle(input logic w, input logic rdy, input logic to, input logic wr,
                                input logic [31:0] rd, input logic mv, input logic dv);
        @(negedge clk);
        check_val("wait",      {31'd0, pcpi_wait},      {31'd0, w});
        check_val("ready",     {31'd0, pcpi_ready},     {31'd0, rdy});
        check_val("timeout",   {31'd0, pcpi_timeout},   {31'd0, to});
        check_val("wr",        {31'd0, pcpi_wr},        {31'd0, wr});
        check_val("rd",        pcpi_rd,                 rd);
        check_val("mul_valid", {31'd0, pcpi_mul_valid}, {31'd0, mv});
        check_val("div_valid", {31'd0, pcpi_div_valid}, {31'd0, dv});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            pcpi_valid = 1'b0;
            drive_noise();
            expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        end
    endtask

    // k: BUSY cycle index at which the selected unit answers (k >= T means never).
    // abort_at >= 0: core withdraws valid in BUSY cycle abort_at. hold: cycles for a non-match.
    task automatic run_txn(input logic [31:0] insn, input int k, input int abort_at,
                           input logic swr, input logic [31:0] srd, input int hold);
        logic m, d, to, sr, fin, busy, act;
        logic [31:0] g;
        int r_cyc;
        m = is_m(insn);
        d = insn[14];
        pcpi_insn = insn;
        if (!m) begin
            for (int c = 0; c < hold; c++) begin
                pcpi_valid = 1'b1;
                drive_noise();
                expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            end
        end else if (abort_at >= 0) begin
            for (int c = 0; c <= abort_at + 3; c++) begin
                pcpi_valid = (c <= abort_at);
                drive_units(d, 1'b0, 1'b0, 32'd0);
                act = (c >= 1) && (c <= abort_at + 1);
                expect_cycle(act, 1'b0, 1'b0, 1'b0, 32'd0, act && !d, act && d);
            end
        end else begin
            to    = (k >= T);
            r_cyc = to ? T + 1 : k + 2;
            for (int c = 0; c <= r_cyc; c++) begin
                pcpi_valid = 1'b1;
                g  = $urandom;
                sr = !to && (c == k + 1);
                drive_units(d, sr, sr ? swr : g[0], sr ? srd : $urandom);
                fin  = (c == r_cyc);
                busy = (c >= 1) && (c < r_cyc);
                expect_cycle(c >= 1, fin, fin && to, fin && !to && swr,
                             (fin && !to) ? srd : 32'd0, busy && !d, busy && d);
            end
            if (!to) begin
                if (d) exp_div++;
                else   exp_mul++;
            end
        end
        pcpi_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r, insn;
        int kind;
        reset = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn = 32'd0;
        drive_units(1'b0, 1'b0, 1'b0, 32'd0);
        pcpi_div_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        run_txn(32'h0220C0B3, 2, -1, 1'b1, 32'd14, 0);
        run_txn(32'h022080B3, 3, -1, 1'b1, 32'd42, 0);
        run_txn(32'h002080B3, 0, -1, 1'b0, 32'd0, 20);
        run_txn(32'h0220C0B3, T, -1, 1'b1, 32'hDEAD_BEEF, 0);
        run_txn(32'h022080B3, T - 1, -1, 1'b1, 32'h1234_5678, 0);
        run_txn(32'h0220C0B3, 0, -1, 1'b0, 32'h0000_0077, 0);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            r = $urandom;
            insn = {7'b0000001, r[17:0], 7'b0110011};
            if (kind < 2) begin
                insn = $urandom;
                while (is_m(insn)) insn = $urandom;
                run_txn(insn, 0, -1, 1'b0, 32'd0, $urandom_range(1, 5));
            end else if (kind == 2) begin
                run_txn(insn, 0, $urandom_range(0, T - 2), 1'b0, 32'd0, 0);
            end else begin
                run_txn(insn, $urandom_range(0, T + 2), -1, r[20], $urandom, 0);
            end
            if (r[31]) idle_cycles($urandom_range(1, 2));
        end

`ifdef PCPI_DISPATCH_PERF_EN
        @(negedge clk);
        check_val("perf_mul", perf_mul_cnt, exp_mul);
        check_val("perf_div", perf_div_cnt, exp_div);
        @(posedge clk);
        #1;
`endif

        // Reset lands in BUSY together with the divider's answer.
        pcpi_insn = 32'h0220C0B3;
        pcpi_valid = 1'b1;
        drive_units(1'b1, 1'b0, 1'b0, 32'd0);
        expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive_units(1'b1, 1'b0, 1'b0, 32'd0);
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        reset = 1'b1;
        drive_units(1'b1, 1'b1, 1'b1, 32'd99);
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        reset = 1'b0;
        idle_cycles(4);

`ifdef PCPI_DISPATCH_PERF_EN
        @(negedge clk);
        check_val("perf_mul_rst", perf_mul_cnt, 32'd0);
        check_val("perf_div_rst", perf_div_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
